data_bus_ram_slave: RTL and testbench

Word-addressed on-chip RAM responder for the DATA_BUS protocol, i.e. the device end of an interconnect slave port. It accepts req/gnt address-phase handshakes with a configurable number of wait states. It returns exactly one rvalid response per grant, one cycle after the grant, with err signalling. It publishes its address window on conf so the interconnect can decode it.

---
 rtl/data_bus_ram_slave.sv | 64 ++++++
 tb/tb_data_bus_ram_slave.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_bus_ram_slave.sv
// data_bus_ram_slave: word-addressed RAM responder for DATA_BUS with configurable wait states
package data_bus_pkg;
  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] addr_mask;
  } config_type;
endpackage

module data_bus_ram_slave
  import data_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output config_type  conf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [31:0] mem [DEPTH];
  logic [3:0] cnt_q, cnt_d;
  logic rvalid_q, err_q;
  logic [31:0] rdata_q;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic bad;
  assign offset = addr_i & ~ADDR_MASK;
  assign idx = AW'(offset >> 2);
  assign bad = (|addr_i[1:0]) || ((offset >> (AW + 2)) != '0);
  assign gnt_o = !rst && req_i && (cnt_q == WS);
  always_comb cnt_d = (req_i && !gnt_o) ? cnt_q + 4'd1 : 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= gnt_o;
      err_q    <= gnt_o && bad;
      rdata_q  <= (gnt_o && !we_i && !bad) ? mem[idx] : '0;
    end
  end
  always_ff @(posedge clk)
    if (gnt_o && we_i && be_i && !bad) mem[idx] <= wdata_i;
  // masking with rst drops a response whose grant preceded the reset
  assign rvalid_o = rvalid_q && !rst;
  assign err_o    = err_q && !rst;
  assign rdata_o  = rst ? '0 : rdata_q;
  assign conf_o   = '{base_addr: BASE_ADDR, addr_mask: ADDR_MASK};
endmodule

// File: tb/tb_data_bus_ram_slave.sv
// tb_data_bus_ram_slave: table vectors, random model check (WAIT_STATES=0) and wait-state sequences (WAIT_STATES=3)
module tb_data_bus_ram_slave;
  import data_bus_pkg::*;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] B    = 32'h1000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_F000;

  logic clk = 1'b1;
  logic rst;
  logic req, we, be, gnt, rv, er;
  logic [31:0] addr, wdata, rd;
  config_type cf;
  logic req3, we3, be3, gnt3, rv3, er3;
  logic [31:0] addr3, wdata3, rd3;
  config_type cf3;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [DEPTH];
  logic pv = 1'b0, pe = 1'b0;
  logic [31:0] prd = '0;

  always #5 clk = ~clk;

  data_bus_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(B), .ADDR_MASK(MASK)) dut0 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rv), .err_o(er), .rdata_o(rd), .conf_o(cf));

  data_bus_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(B), .ADDR_MASK(MASK)) dut3 (
    .clk(clk), .rst(rst), .req_i(req3), .addr_i(addr3), .we_i(we3), .be_i(be3), .wdata_i(wdata3),
    .gnt_o(gnt3), .rvalid_o(rv3), .err_o(er3), .rdata_o(rd3), .conf_o(cf3));

  typedef struct {
    logic        req, we, be;
    logic [31:0] addr, wdata;
    logic        g, rv, er;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // one cycle on dut0, checked against the reference memory model
  task automatic cyc0(input logic r, input logic w, input logic b, input logic [31:0] a,
                      input logic [31:0] d, input logic rs);
    logic [31:0] off;
    logic e, g;
    rst = rs; req = r; we = w; be = b; addr = a; wdata = d;
    g = r && !rs;
    @(negedge clk);
    chk("m_gnt", {31'b0, gnt}, {31'b0, g});
    chk("m_rvalid", {31'b0, rv}, {31'b0, pv && !rs});
    chk("m_err", {31'b0, er}, {31'b0, pe && !rs});
    chk("m_rdata", rd, rs ? 32'h0 : prd);
    off = a & ~MASK;
    e = (a % 4 != 0) || (off >= DEPTH * 4);
    if (g) begin
      pv = 1'b1;
      pe = e;
      prd = (!w && !e) ? mem_m[off / 4] : 32'h0;
      if (w && b && !e) mem_m[off / 4] = d;
    end else begin
      pv = 1'b0; pe = 1'b0; prd = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc3(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic eg, input logic erv, input logic [31:0] erd);
    req3 = r; we3 = w; be3 = 1'b1; addr3 = a; wdata3 = d;
    @(negedge clk);
    chk("w3_gnt", {31'b0, gnt3}, {31'b0, eg});
    chk("w3_rvalid", {31'b0, rv3}, {31'b0, erv});
    chk("w3_err", {31'b0, er3}, 32'h0);
    chk("w3_rdata", rd3, erd);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, B + 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, B + 32'h10,  32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, B + 32'h2,   32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, B + 32'h400, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, B,           32'h55,       1'b1, 1'b1, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, B + 32'h400, 32'h1234,     1'b1, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, B,           32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, B + 32'h8,   32'h0000AAAA, 1'b1, 1'b1, 1'b0, 32'h55};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, B + 32'h8,   32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, B + 32'h8,   32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b1, 1'b0, 32'h0000AAAA};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    req3 = 1'b0; we3 = 1'b0; be3 = 1'b0; addr3 = '0; wdata3 = '0;
    // reset held with a write request pending
    rst = 1'b1; req = 1'b1; we = 1'b1; be = 1'b1; addr = B; wdata = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {31'b0, gnt}, 32'h0);
      chk("rst_rvalid", {31'b0, rv}, 32'h0);
      chk("rst_err", {31'b0, er}, 32'h0);
      chk("rst_rdata", rd, 32'h0);
      chk("rst_gnt3", {31'b0, gnt3}, 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk("conf_base", cf.base_addr, B);
    chk("conf_mask", cf.addr_mask, MASK);
    chk("conf3_base", cf3.base_addr, B);
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; we = tbl[i].we; be = tbl[i].be; addr = tbl[i].addr; wdata = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), {31'b0, gnt}, {31'b0, tbl[i].g});
      chk($sformatf("tbl%0d_rvalid", i), {31'b0, rv}, {31'b0, tbl[i].rv});
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      @(posedge clk); #1;
    end
    for (int i = 0; i < int'(DEPTH); i++) cyc0(1'b1, 1'b1, 1'b1, B + 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(9);
      a = (sel == 0) ? B + $urandom_range(32'hFFF)
        : (sel == 1) ? B + 32'($urandom_range(DEPTH - 1) * 4 + $urandom_range(3, 1))
        : B + 32'($urandom_range(DEPTH - 1) * 4);
      cyc0($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(3) != 0, a, $urandom, 1'b0);
    end
    // read granted, then reset in the response cycle with a write pending
    cyc0(1'b1, 1'b0, 1'b0, B + 32'd20, 32'h0, 1'b0);
    cyc0(1'b1, 1'b1, 1'b1, B + 32'd20, 32'h0BADF00D, 1'b1);
    cyc0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc0(1'b1, 1'b0, 1'b0, B + 32'd20, 32'h0, 1'b0);
    cyc0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    req = 1'b0;
    // three wait states: write, back-to-back read, abandoned request, fresh request
    for (int i = 0; i < 3; i++) cyc3(1'b1, 1'b1, B + 32'h4, 32'hCAFE0004, 1'b0, 1'b0, 32'h0);
    cyc3(1'b1, 1'b1, B + 32'h4, 32'hCAFE0004, 1'b1, 1'b0, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE0004);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc3(1'b1, 1'b0, B + 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE0004);
    cyc3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
